// File: rtl/data_sram_resp_pkg.sv
// Shared constants and types for the data-side SRAM responder.
// DSRAM_LFSR_SEED only matters when DSRAM_RAND_STALL_EN is defined.
package data_sram_resp_pkg;

    localparam int          DSRAM_AW        = 14;
    localparam int          DSRAM_LAT       = 2;
    localparam int          DSRAM_QDEPTH    = 2;
    localparam logic [15:0] DSRAM_LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    // One queued response: the word to return and its remaining wait cycles.
    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  cnt;
    } qentry_t;

endpackage

// File: rtl/dsram_resp_fifo.sv
// In-order response queue: each entry counts down from LATENCY-1 and is
// presented as data_ok once it reaches the head with a zero count.
module dsram_resp_fifo
    import data_sram_resp_pkg::*;
#(
    parameter int DEPTH   = DSRAM_QDEPTH,
    parameter int LATENCY = DSRAM_LAT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        push_i,
    input  logic [31:0] pushData_i,
    output logic        dataOk_o,
    output logic [31:0] headData_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int          PW       = $clog2(DEPTH);
    localparam int          CW       = PW + 1;
    localparam logic [2:0]  LOAD_CNT = 3'(LATENCY - 1);

    qentry_t         entry_q [DEPTH];
    qentry_t         entry_d [DEPTH];
    logic [PW-1:0]   wrPtr_q;
    logic [PW-1:0]   wrPtr_d;
    logic [PW-1:0]   rdPtr_q;
    logic [PW-1:0]   rdPtr_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign dataOk_o   = !empty_o && (entry_q[rdPtr_q].cnt == 3'd0);
    assign headData_o = dataOk_o ? entry_q[rdPtr_q].data : 32'd0;

    // Every countdown ticks each cycle; a freshly pushed entry overrides its slot.
    always_comb begin
        entry_d = entry_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_q[i].cnt != 3'd0) begin
                entry_d[i].cnt = entry_q[i].cnt - 3'd1;
            end
        end
        if (push_i) begin
            entry_d[wrPtr_q].data = pushData_i;
            entry_d[wrPtr_q].cnt  = LOAD_CNT;
            wrPtr_d               = wrPtr_q + PW'(1);
        end
        if (dataOk_o) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        if (push_i && !dataOk_o) begin
            count_d = count_q + CW'(1);
        end else if (!push_i && dataOk_o) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: word array with byte-strobe writes feeding a fixed-latency in-order response queue.
// Define DSRAM_RAND_STALL_EN to additionally throttle addr_ok with a free-running 16-bit LFSR.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int AW      = DSRAM_AW,
    parameter int LATENCY = DSRAM_LAT,
    parameter int QDEPTH  = DSRAM_QDEPTH
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int NWORDS = 1 << AW;

    if (LATENCY < 1 || LATENCY > 7) begin : gBadLatency
        $error("data_sram_resp: LATENCY must be in 1..7");
    end
    if (QDEPTH < 2 || QDEPTH > 8 || (QDEPTH & (QDEPTH - 1)) != 0) begin : gBadDepth
        $error("data_sram_resp: QDEPTH must be a power of two in 2..8");
    end

    logic [31:0]   mem_q [NWORDS];
    logic [AW-1:0] wordIdx;
    logic          accept;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [31:0]   pushData;
    logic          unusedBits;

    // Size and the untranslated address bits are carried for the master's benefit only.
    assign unusedBits = ^{data_sram_size, data_sram_addr, fifoEmpty};

    assign wordIdx  = data_sram_addr[AW+1:2];
    assign accept   = data_sram_req && data_sram_addr_ok;
    assign pushData = data_sram_wr ? 32'd0 : mem_q[wordIdx];

    // The array has no reset: its contents survive rstn, only in-flight responses are flushed.
    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wstrb[i]) begin
                    mem_q[wordIdx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef DSRAM_RAND_STALL_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= DSRAM_LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign data_sram_addr_ok = !fifoFull && lfsr_q[0];
`else
    assign data_sram_addr_ok = !fifoFull;
`endif

    dsram_resp_fifo #(
        .DEPTH   (QDEPTH),
        .LATENCY (LATENCY)
    ) uFifo (
        .clk        (clk),
        .rstn       (rstn),
        .push_i     (accept),
        .pushData_i (pushData),
        .dataOk_o   (data_sram_data_ok),
        .headData_o (data_sram_rdata),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: two instances (LATENCY 2 and 4, QDEPTH 2) checked every cycle against a
// timestamp-based reference model, plus directed checks of fixed values from the test plan.
module tb_data_sram_resp;

    localparam int AW   = 6;
    localparam int NW   = 1 << AW;
    localparam int QD   = 2;
    localparam int LAT0 = 2;
    localparam int LAT1 = 4;
    localparam int LOGN = 4096;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  reqV = 2'b00;
    logic        wr   = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] addr = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [1:0]  okV;
    logic [1:0]  dokV;
    logic [31:0] rd0;
    logic [31:0] rd1;

    int checks = 0;
    int passed = 0;

    // Reference model state: per-instance memory image and a log of expected responses with due cycles.
    logic [31:0] memM  [2][NW];
    logic [31:0] expD  [2][LOGN];
    int          dueC  [2][LOGN];
    int          pushN [2];
    int          popN  [2];
    int          obsResp [2];
    int          cyc = 0;
    logic [15:0] lfsrM = 16'hACE1;

    data_sram_resp #(.AW(AW), .LATENCY(LAT0), .QDEPTH(QD)) u0 (
        .clk               (clk),
        .rstn              (rstn),
        .data_sram_req     (reqV[0]),
        .data_sram_wr      (wr),
        .data_sram_size    (size),
        .data_sram_addr    (addr),
        .data_sram_wstrb   (wstrb),
        .data_sram_wdata   (wdata),
        .data_sram_addr_ok (okV[0]),
        .data_sram_data_ok (dokV[0]),
        .data_sram_rdata   (rd0)
    );

    data_sram_resp #(.AW(AW), .LATENCY(LAT1), .QDEPTH(QD)) u1 (
        .clk               (clk),
        .rstn              (rstn),
        .data_sram_req     (reqV[1]),
        .data_sram_wr      (wr),
        .data_sram_size    (size),
        .data_sram_addr    (addr),
        .data_sram_wstrb   (wstrb),
        .data_sram_wdata   (wdata),
        .data_sram_addr_ok (okV[1]),
        .data_sram_data_ok (dokV[1]),
        .data_sram_rdata   (rd1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_0111;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    // One model cycle for instance k, evaluated at the falling edge between two rising edges.
    task automatic modelStep(input int k);
        logic        expOk;
        logic        expDok;
        logic [31:0] expRd;
        logic [31:0] mask;
        logic [31:0] rdObs;
        int          idx;
        int          lat;
        rdObs = (k == 0) ? rd0 : rd1;
        lat   = (k == 0) ? LAT0 : LAT1;
        if (dokV[k]) obsResp[k]++;
        if (!rstn) begin
            popN[k] = pushN[k];
            checkOutput($sformatf("rst_addr_ok%0d", k), 32'(okV[k]), 32'd1);
            checkOutput($sformatf("rst_data_ok%0d", k), 32'(dokV[k]), 32'd0);
            checkOutput($sformatf("rst_rdata%0d", k), rdObs, 32'd0);
            return;
        end
        expOk = (pushN[k] - popN[k]) < QD;
`ifdef DSRAM_RAND_STALL_EN
        expOk = expOk && lfsrM[0];
`endif
        expDok = (pushN[k] != popN[k]) && (dueC[k][popN[k] % LOGN] == cyc);
        expRd  = expDok ? expD[k][popN[k] % LOGN] : 32'd0;
        checkOutput($sformatf("addr_ok%0d@%0d", k, cyc), 32'(okV[k]), 32'(expOk));
        checkOutput($sformatf("data_ok%0d@%0d", k, cyc), 32'(dokV[k]), 32'(expDok));
        checkOutput($sformatf("rdata%0d@%0d", k, cyc), rdObs, expRd);
        if (expDok) popN[k]++;
        if (reqV[k] && expOk) begin
            idx = int'(addr[AW+1:2]);
            if (wr) begin
                mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
                memM[k][idx] = (memM[k][idx] & ~mask) | (wdata & mask);
                expD[k][pushN[k] % LOGN] = 32'd0;
            end else begin
                expD[k][pushN[k] % LOGN] = memM[k][idx];
            end
            dueC[k][pushN[k] % LOGN] = cyc + lat;
            pushN[k]++;
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) modelStep(k);
`ifdef DSRAM_RAND_STALL_EN
        if (!rstn) lfsrM = 16'hACE1;
        else lfsrM = {lfsrM[14:0], lfsrM[15] ^ lfsrM[13] ^ lfsrM[12] ^ lfsrM[10]};
`endif
        cyc++;
    end

    task automatic idle(input int n);
        reqV = 2'b00;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one request to the instances in sel and holds it until each has accepted it.
    task automatic applyStimulus(input logic [1:0] sel, input logic w, input logic [31:0] a,
                                 input logic [3:0] s, input logic [31:0] d, input logic [1:0] sz);
        logic [1:0] got;
        wr = w; addr = a; wstrb = s; wdata = d; size = sz; reqV = sel;
        for (int t = 0; t < 80 && reqV != 2'b00; t++) begin
            @(negedge clk);
            got = reqV & okV;
            @(posedge clk);
            #1;
            reqV = reqV & ~got;
        end
        checkOutput("accept_timeout", 32'(reqV), 32'd0);
        reqV = 2'b00;
    endtask

    task automatic doOp(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        input logic [1:0] sz, output logic [31:0] r, output int latency);
        applyStimulus(2'b01, w, a, s, d, sz);
        r = 'x;
        latency = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (dokV[0]) begin
                r = rd0;
                latency = t;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] respD [4];
        logic [3:0]  okPat;
        logic [1:0]  got;
        int          lat;
        int          nResp;
        int          ai;
        int          nAcc;
        int          snapAcc;
        int          snapResp;

        for (int k = 0; k < 2; k++) begin
            pushN[k] = 0; popN[k] = 0; obsResp[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_addr_ok", 32'(okV[0]), 32'd1);
        checkOutput("reset_data_ok", 32'(dokV[0]), 32'd0);
        checkOutput("reset_rdata", rd0, 32'd0);
        rstn = 1'b1;
        idle(2);

        // Give both instances a known image of every word.
        for (int i = 0; i < NW; i++) begin
            a = $urandom;
            a[AW+1:2] = AW'(i);
            applyStimulus(2'b11, 1'b1, a, 4'hF, pat(i), 2'd2);
        end
        idle(8);

        doOp(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 2'd2, r, lat);
        checkOutput("write_rdata", r, 32'd0);
        checkOutput("write_latency", 32'(lat), 32'(LAT0 - 1));
        doOp(1'b0, 32'h10, 4'h0, 32'h0, 2'd2, r, lat);
        checkOutput("read_rdata", r, 32'hDEADBEEF);
        checkOutput("read_latency", 32'(lat), 32'(LAT0 - 1));
        doOp(1'b1, 32'h10, 4'b0101, 32'h11223344, 2'd2, r, lat);
        checkOutput("strobe_write_rdata", r, 32'd0);
        doOp(1'b0, 32'h13, 4'h0, 32'h0, 2'd0, r, lat);
        checkOutput("strobe_read_rdata", r, 32'hDE22BE44);
        doOp(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 2'd2, r, lat);
        doOp(1'b0, 32'h20, 4'h0, 32'h0, 2'd2, r, lat);
        checkOutput("zero_strobe_noop", r, pat(8));
        idle(4);

        // Back-to-back reads of words 0..3 on the LATENCY=2 instance.
        for (int i = 0; i < 4; i++) respD[i] = 'x;
        nResp = 0; ai = 0;
        wr = 1'b0; addr = 32'h0; wstrb = 4'h0; size = 2'd2; reqV = 2'b01;
        for (int t = 0; t < 80 && nResp < 4; t++) begin
            @(negedge clk);
            if (dokV[0] && nResp < 4) begin
                respD[nResp] = rd0;
                nResp++;
            end
            got = reqV & okV;
            @(posedge clk);
            #1;
            if (got[0]) begin
                ai++;
                if (ai >= 4) reqV = 2'b00;
                else addr = 32'(ai * 4);
            end
        end
        reqV = 2'b00;
        checkOutput("b2b_resp_count", 32'(nResp), 32'd4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("b2b_data%0d", i), respD[i], pat(i));
        idle(10);

        // LATENCY=4 instance with req held: queue fills after two accepts.
        snapAcc = pushN[1]; snapResp = obsResp[1]; okPat = 4'b0000;
        wr = 1'b0; addr = 32'h4; reqV = 2'b10;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            if (t < 4) okPat = {okPat[2:0], okV[1]};
            @(posedge clk);
            #1;
        end
        reqV = 2'b00;
`ifndef DSRAM_RAND_STALL_EN
        checkOutput("full_addr_ok_pattern", 32'(okPat), 32'b1100);
`endif
        idle(12);
        checkOutput("full_no_lost_resp", 32'(obsResp[1] - snapResp), 32'(pushN[1] - snapAcc));

        // Random traffic on both instances, avoiding words 0..7 so the directed words stay intact.
        snapAcc = pushN[0] + pushN[1]; snapResp = obsResp[0] + obsResp[1];
        for (int t = 0; t < 1000; t++) begin
            r = $urandom;
            reqV  = {2{r[0] | r[1]}};
            wr    = r[2];
            size  = 2'(r[4:3] % 3);
            wstrb = r[8:5];
            wdata = $urandom;
            a = $urandom;
            a[AW+1:2] = AW'(8 + ($urandom % (NW - 8)));
            addr = a;
            @(posedge clk);
            #1;
        end
        idle(12);
        checkOutput("random_resp_eq_accept", 32'(obsResp[0] + obsResp[1] - snapResp),
                    32'(pushN[0] + pushN[1] - snapAcc));

        // Reset with two reads outstanding on the LATENCY=2 instance.
        nAcc = 0;
        wr = 1'b0; addr = 32'h0; reqV = 2'b01;
        for (int t = 0; t < 80 && nAcc < 2; t++) begin
            @(negedge clk);
            got = reqV & okV;
            @(posedge clk);
            #1;
            if (got[0]) nAcc++;
        end
        rstn = 1'b0;
        reqV = 2'b00;
        #1;
        checkOutput("flight_accepts", 32'(nAcc), 32'd2);
        checkOutput("flight_rst_data_ok", 32'(dokV[0]), 32'd0);
        checkOutput("flight_rst_rdata", rd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        snapResp = obsResp[0];
        idle(10);
        checkOutput("no_stale_resp", 32'(obsResp[0] - snapResp), 32'd0);
        doOp(1'b0, 32'h10, 4'h0, 32'h0, 2'd2, r, lat);
        checkOutput("post_reset_read", r, 32'hDE22BE44);
        checkOutput("post_reset_latency", 32'(lat), 32'(LAT0 - 1));
        idle(4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
